// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded BCD-style timer counter.
//   DIGIT_W   : width of one digit cell
//   MMSS_MODS : per-digit moduli for an MM:SS display (10, 6, 10, 10 from digit 0 up)
//   mod_of()  : extracts the modulus field of digit i from a packed MODS vector
package timer_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [31:0] MMSS_MODS = 32'h0AAA_AA6A;

  // Modulus of digit i, digit 0 in bits [3:0].
  function automatic logic [DIGIT_W-1:0] mod_of(input logic [31:0] mods, input int unsigned i);
    return mods[DIGIT_W*i +: DIGIT_W];
  endfunction

endpackage

// File: rtl/timer_digit.sv
// One digit cell of the cascaded down-counter (purely combinational).
// Ports:
//   val_i       : current digit value
//   borrow_i    : borrow-in from the next-lower digit (1 = decrement this digit)
//   data_i      : parallel load value for this digit
//   load_i      : select load data (clamped to MOD-1) instead of decrementing
//   val_nxt_c_o : next digit value
//   borrow_c_o  : borrow-out to the next-higher digit
module timer_digit
  import timer_pkg::*;
#(
  parameter int unsigned MOD = 10
) (
  input  logic [DIGIT_W-1:0] val_i,
  input  logic               borrow_i,
  input  logic [DIGIT_W-1:0] data_i,
  input  logic               load_i,
  output logic [DIGIT_W-1:0] val_nxt_c_o,
  output logic               borrow_c_o
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MOD - 1);
  localparam logic [DIGIT_W:0]   MOD_VAL = (DIGIT_W + 1)'(MOD);

  // Next value: clamped load, wrap-on-borrow decrement, or hold.
  always_comb begin
    val_nxt_c_o = val_i;
    if (load_i) begin
      val_nxt_c_o = ({1'b0, data_i} >= MOD_VAL) ? MAX_VAL : data_i;
    end else if (borrow_i) begin
      val_nxt_c_o = (val_i == '0) ? MAX_VAL : (val_i - DIGIT_W'(1));
    end
  end

  assign borrow_c_o = borrow_i & (val_i == '0);

endmodule

// File: rtl/timer_digits.sv
// Multi-digit cascaded down-counter for the microwave timer display.
// Parameters: DIGITS (1..8), MODS (packed 4-bit modulus per digit), WRAP (0 = hold at zero,
// 1 = reload every digit to MOD-1 when decremented at zero).
// Ports:
//   clk   : system clock, rising edge
//   clr   : synchronous active-high clear
//   loadn : active-low parallel load (beats en)
//   en    : count strobe, one decrement per high cycle
//   data  : load value, digit i in [4i+3:4i]
//   out   : current count (registered)
//   zero  : registered, high iff out == 0
//   done  : registered one-cycle pulse after a decrement reaches zero
module timer_digits
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter logic [31:0] MODS   = MMSS_MODS,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      loadn,
  input  logic                      en,
  input  logic [DIGIT_W*DIGITS-1:0] data,
  output logic [DIGIT_W*DIGITS-1:0] out,
  output logic                      zero,
  output logic                      done
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  logic [W-1:0]    out_q, out_d, nxt_c;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic [DIGITS:0] borrow_c;
  logic            load_c;

  assign load_c      = ~loadn;
  assign borrow_c[0] = 1'b1;

  // Digit cells; the borrow chain ripples combinationally through all digits.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    timer_digit #(
      .MOD(32'(mod_of(MODS, i)))
    ) u_digit (
      .val_i      (out_q[DIGIT_W*i +: DIGIT_W]),
      .borrow_i   (borrow_c[i]),
      .data_i     (data[DIGIT_W*i +: DIGIT_W]),
      .load_i     (load_c),
      .val_nxt_c_o(nxt_c[DIGIT_W*i +: DIGIT_W]),
      .borrow_c_o (borrow_c[i+1])
    );
  end

  // Borrow out of the top digit means the count was already zero.
  always_comb begin
    out_d  = out_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (load_c) begin
      out_d  = nxt_c;
      zero_d = (nxt_c == '0);
    end else if (en) begin
      if (!borrow_c[DIGITS]) begin
        out_d  = nxt_c;
        zero_d = (nxt_c == '0);
        done_d = (nxt_c == '0);
      end else if (WRAP) begin
        out_d  = nxt_c;
        zero_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_q  <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign done = done_q;

endmodule

// File: tb/tb_timer_digits.sv
// Directed bench for timer_digits: an MM:SS hold-at-zero instance and a wrapping instance
// share all inputs; expected values are hand-computed.
module tb_timer_digits;

  logic        clk = 1'b0;
  logic        clr;
  logic        loadn;
  logic        en;
  logic [15:0] data;
  logic [15:0] out_h, out_w;
  logic        zero_h, zero_w;
  logic        done_h, done_w;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_digits #(.DIGITS(4), .MODS(32'h0AAA_AA6A), .WRAP(1'b0)) dut (
    .clk(clk), .clr(clr), .loadn(loadn), .en(en), .data(data),
    .out(out_h), .zero(zero_h), .done(done_h)
  );

  timer_digits #(.DIGITS(4), .MODS(32'h0AAA_AA6A), .WRAP(1'b1)) dut_w (
    .clk(clk), .clr(clr), .loadn(loadn), .en(en), .data(data),
    .out(out_w), .zero(zero_w), .done(done_w)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    clr = 1'b0; loadn = 1'b0; en = 1'b0; data = v;
    tick();
    loadn = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1; loadn = 1'b1; en = 1'b0; data = 16'h1234;
    tick();
    clr = 1'b0;
    tests++; if (out_h !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out_h); end
    tests++; if (zero_h !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero_h); end
    tests++; if (done_h !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_h); end
    tests++; if (out_w !== 16'h0000 || zero_w !== 1'b1) begin errors++; $display("FAIL reset_wrap got=%h/%b exp=0000/1", out_w, zero_w); end
  endtask

  task automatic test_borrow();
    do_load(16'h0100);
    tests++; if (out_h !== 16'h0100 || zero_h !== 1'b0) begin errors++; $display("FAIL load_0100 got=%h/%b exp=0100/0", out_h, zero_h); end
    en = 1'b1; tick(); en = 1'b0;
    tests++; if (out_h !== 16'h0059) begin errors++; $display("FAIL borrow_0100 got=%h exp=0059", out_h); end
    tests++; if (zero_h !== 1'b0 || done_h !== 1'b0) begin errors++; $display("FAIL borrow_0100_flags got=%b%b exp=00", zero_h, done_h); end
    do_load(16'h1000);
    en = 1'b1; tick(); en = 1'b0;
    tests++; if (out_h !== 16'h0959) begin errors++; $display("FAIL borrow_1000 got=%h exp=0959", out_h); end
    en = 1'b1; tick(); en = 1'b0;
    tests++; if (out_h !== 16'h0958) begin errors++; $display("FAIL dec_0959 got=%h exp=0958", out_h); end
  endtask

  task automatic test_count_zero();
    do_load(16'h0002);
    en = 1'b1; tick();
    tests++; if (out_h !== 16'h0001 || done_h !== 1'b0 || zero_h !== 1'b0) begin errors++; $display("FAIL cz_0001 got=%h/%b/%b exp=0001/0/0", out_h, zero_h, done_h); end
    tick();
    tests++; if (out_h !== 16'h0000 || zero_h !== 1'b1) begin errors++; $display("FAIL cz_0000 got=%h/%b exp=0000/1", out_h, zero_h); end
    tests++; if (done_h !== 1'b1) begin errors++; $display("FAIL cz_done got=%b exp=1", done_h); end
    tests++; if (out_w !== 16'h0000 || done_w !== 1'b1) begin errors++; $display("FAIL cz_wrap_done got=%h/%b exp=0000/1", out_w, done_w); end
    tick();
    tests++; if (out_h !== 16'h0000 || zero_h !== 1'b1 || done_h !== 1'b0) begin errors++; $display("FAIL cz_hold got=%h/%b/%b exp=0000/1/0", out_h, zero_h, done_h); end
    tests++; if (out_w !== 16'h9959 || zero_w !== 1'b0 || done_w !== 1'b0) begin errors++; $display("FAIL wrap_9959 got=%h/%b/%b exp=9959/0/0", out_w, zero_w, done_w); end
    en = 1'b0; tick();
    tests++; if (out_w !== 16'h9959 || out_h !== 16'h0000 || done_h !== 1'b0) begin errors++; $display("FAIL idle_hold got=%h/%h/%b exp=9959/0000/0", out_w, out_h, done_h); end
  endtask

  task automatic test_clamp();
    do_load(16'h0079);
    tests++; if (out_h !== 16'h0059) begin errors++; $display("FAIL clamp_0079 got=%h exp=0059", out_h); end
    do_load(16'h00BC);
    tests++; if (out_h !== 16'h0059) begin errors++; $display("FAIL clamp_00BC got=%h exp=0059", out_h); end
    do_load(16'hFFFF);
    tests++; if (out_h !== 16'h9959) begin errors++; $display("FAIL clamp_FFFF got=%h exp=9959", out_h); end
    do_load(16'h0000);
    tests++; if (out_h !== 16'h0000 || zero_h !== 1'b1 || done_h !== 1'b0) begin errors++; $display("FAIL load_zero got=%h/%b/%b exp=0000/1/0", out_h, zero_h, done_h); end
  endtask

  task automatic test_simultaneous();
    do_load(16'h0001);
    loadn = 1'b0; en = 1'b1; data = 16'h0030; tick();
    tests++; if (out_h !== 16'h0030) begin errors++; $display("FAIL load_beats_en got=%h exp=0030", out_h); end
    do_load(16'h0001);
    loadn = 1'b0; en = 1'b1; data = 16'h0000; tick();
    tests++; if (out_h !== 16'h0000 || zero_h !== 1'b1 || done_h !== 1'b0) begin errors++; $display("FAIL load_vs_zero got=%h/%b/%b exp=0000/1/0", out_h, zero_h, done_h); end
    do_load(16'h0045);
    clr = 1'b1; loadn = 1'b0; en = 1'b1; data = 16'h0030; tick();
    clr = 1'b0; loadn = 1'b1; en = 1'b0;
    tests++; if (out_h !== 16'h0000 || zero_h !== 1'b1) begin errors++; $display("FAIL clr_beats_load got=%h/%b exp=0000/1", out_h, zero_h); end
  endtask

  task automatic test_reset_midcount();
    do_load(16'h0001);
    clr = 1'b1; en = 1'b1; tick();
    clr = 1'b0;
    tests++; if (out_h !== 16'h0000 || done_h !== 1'b0) begin errors++; $display("FAIL clr_midcount got=%h/%b exp=0000/0", out_h, done_h); end
    en = 1'b0; tick();
    tests++; if (done_h !== 1'b0) begin errors++; $display("FAIL clr_no_pending_done got=%b exp=0", done_h); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_out [4];
    logic        exp_done[4];
    exp_out  = '{16'h0002, 16'h0001, 16'h0000, 16'h0000};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_load(16'h0003);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (out_h !== exp_out[k] || done_h !== exp_done[k]) begin
        errors++;
        $display("FAIL b2b_step%0d got=%h/%b exp=%h/%b", k, out_h, done_h, exp_out[k], exp_done[k]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    clr = 1'b0; loadn = 1'b1; en = 1'b0; data = '0;
    test_reset();
    test_borrow();
    test_count_zero();
    test_clamp();
    test_simultaneous();
    test_reset_midcount();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
